alu_execute: RTL and testbench
==============================

ALU_EXECUTE -- requirements
Module: alu_execute

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 32, datapath width (only 32 supported).
REQ-002 SHALL have port: clock  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: aluin1  input  32  signed operand 1 (shift source).
REQ-005 SHALL have port: aluin2  input  32  signed operand 2, immediate or memory read data.
REQ-006 SHALL have port: operation  input  3  operation code.
REQ-007 SHALL have port: opselect  input  3  class: 001 arith/logic, 101 mem read, 000 shift.
REQ-008 SHALL have port: shift_number  input  5  shift amount, 0-31.
REQ-009 SHALL have port: enable_arith  input  1  arith/logic/load op valid this cycle.
REQ-010 SHALL have port: enable_shift  input  1  shift op valid this cycle.
REQ-011 SHALL have port: aluout  output  32  registered result.
REQ-012 SHALL have port: carry  output  1  registered carry/borrow flag.
REQ-013 SHALL have port: result_valid  output  1  registered one-cycle strobe: aluout updated.

Function
REQ-014 Latency SHALL be 1 cycle: inputs sampled at posedge N appear on aluout/carry/result_valid after posedge N.
REQ-015 enable_arith=1 with opselect=001 SHALL compute by operation: 000 ADD aluin1+aluin2; 001 HADD sign-extended aluin1[15:0]+aluin2[15:0]; 010 SUB aluin1-aluin2; 011 NOT ~aluin2; 100 AND; 101 OR; 110 XOR; 111 LHG {aluin2[15:0],16'h0000}.
REQ-016 Carry SHALL be: ADD unsigned carry out of bit 31; HADD carry out of bit 15; SUB 1 when unsigned aluin1<aluin2 (borrow); 0 for all other arith/logic ops.
REQ-017 ADD/SUB/HADD SHALL wrap modulo 2^32 (HADD modulo 2^16 before sign extension); no saturation.
REQ-018 enable_arith=1 with opselect=101 SHALL format aluin2 by operation: 000 sign-ext [7:0]; 100 zero-ext [7:0]; 001 sign-ext [15:0]; 101 zero-ext [15:0]; 011 full word; any other code full word; carry=0.
REQ-019 enable_shift=1 with opselect=000 SHALL shift aluin1 by shift_number: 000 logical left; 001 arithmetic left (same as logical left); 010 logical right zero-fill; 011 arithmetic right sign-fill; carry = last bit shifted out, 0 when shift_number=0.
REQ-020 enable_shift=1 with operation[2]=1 SHALL output aluin1 unchanged, carry=0, result_valid=1.
REQ-021 enable_arith=1 and enable_shift=1 together SHALL execute the arith path (priority); shift ignored.
REQ-022 An enable asserted with a non-matching opselect (e.g. enable_arith with 000 or 100) SHALL be treated as no enable.
REQ-023 With no effective enable, aluout and carry SHALL hold previous values and result_valid SHALL be 0.
REQ-024 result_valid SHALL be 1 for exactly each cycle following an effective enable; back-to-back enables give back-to-back strobes with no bubble.
REQ-025 Block SHALL have no stall/backpressure; every effective enable SHALL produce a result.

Reset
REQ-026 reset=0 SHALL immediately (asynchronously) force aluout=0, carry=0, result_valid=0.
REQ-027 Reset asserted mid-stream SHALL discard the in-flight op; first posedge after deassertion SHALL sample inputs normally.
REQ-028 Outputs SHALL remain at reset values while reset=0 regardless of input activity.

Verification
REQ-029 ADD 32'hFFFF_FFFF + 32'h0000_0001, enable_arith, opselect=001 -> next cycle aluout=0, carry=1, result_valid=1.
REQ-030 SUB 5 - 7 -> aluout=32'hFFFF_FFFE, carry=1; HADD 16'h7FFF+16'h0001 -> aluout=32'hFFFF_8000, carry=0.
REQ-031 opselect=101, aluin2=32'h0000_80F0: op 000 -> 32'hFFFF_FFF0; op 100 -> 32'h0000_00F0; op 001 -> 32'hFFFF_80F0; op 101 -> 32'h0000_80F0.
REQ-032 Shift aluin1=32'h8000_0001, shift_number=4: op 011 -> 32'hF800_0000, carry=0; op 000 -> 32'h0000_0010, carry=0; op 010 with shift_number=1 -> 32'h4000_0000, carry=1.
REQ-033 Three back-to-back ops then both enables 0 for 3 cycles -> three consecutive result_valid pulses, then aluout/carry held at third result, result_valid=0.
REQ-034 reset pulsed low between clock edges during a valid op -> outputs 0 immediately without a clock edge; op after release computes correctly.

Source files
------------

// File: rtl/alu_execute.sv
// -----------------------------------------------------------------------------
// alu_execute
//   Single-stage execute unit. Each cycle one effective operation is selected
//   (arith/logic, memory-read formatting, or shift), and its result, carry and
//   a one-cycle valid strobe are registered. With no effective enable, the result
//   and carry registers hold their values.
//
// Ports
//   clock        in   1   rising-edge clock
//   reset        in   1   asynchronous active-low reset
//   aluin1       in  32   operand 1 / shift source
//   aluin2       in  32   operand 2 / immediate / memory read data
//   operation    in   3   operation code within the selected class
//   opselect     in   3   class: 001 arith/logic, 101 mem read, 000 shift
//   shift_number in   5   shift amount 0..31
//   enable_arith in   1   arith/logic/load op valid (has priority)
//   enable_shift in   1   shift op valid
//   aluout       out 32   registered result
//   carry        out  1   registered carry/borrow/shift-out flag
//   result_valid out  1   registered strobe, high the cycle after an effective op
// -----------------------------------------------------------------------------
module alu_execute #(
  parameter int DATA_WIDTH = 32  // only 32 is supported
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] aluin1,
  input  logic [DATA_WIDTH-1:0] aluin2,
  input  logic [2:0]            operation,
  input  logic [2:0]            opselect,
  input  logic [4:0]            shift_number,
  input  logic                  enable_arith,
  input  logic                  enable_shift,
  output logic [DATA_WIDTH-1:0] aluout,
  output logic                  carry,
  output logic                  result_valid
);

  typedef enum logic [2:0] {
    SEL_SHIFT = 3'b000,
    SEL_ARITH = 3'b001,
    SEL_MEMRD = 3'b101
  } opsel_e;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_HADD = 3'b001,
    OP_SUB  = 3'b010,
    OP_NOT  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_LHG  = 3'b111
  } arith_op_e;

  typedef enum logic [2:0] {
    LD_SB = 3'b000,
    LD_SH = 3'b001,
    LD_UB = 3'b100,
    LD_UH = 3'b101
  } load_op_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SLA = 2'b01,
    SH_SRL = 2'b10,
    SH_SRA = 2'b11
  } shift_op_e;

  logic [DATA_WIDTH-1:0] r_aluout;
  logic                  r_carry;
  logic                  r_valid;

  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_carry;
  logic                  w_valid;

  // Arithmetic helpers: one extra bit on top carries the carry-out.
  logic [DATA_WIDTH:0]   w_add;
  logic [16:0]           w_hadd;
  logic                  w_borrow;

  // Shift helpers. The last bit shifted out of a left shift by n is bit 32-n,
  // which modulo 32 is simply -n; for a right shift it is bit n-1.
  logic [4:0]            w_lsh_idx;
  logic [4:0]            w_rsh_idx;

  logic                  w_do_arith;
  logic                  w_do_memrd;
  logic                  w_do_shift;

  assign w_add     = {1'b0, aluin1} + {1'b0, aluin2};
  assign w_hadd    = {1'b0, aluin1[15:0]} + {1'b0, aluin2[15:0]};
  assign w_borrow  = (aluin1 < aluin2);
  assign w_lsh_idx = 5'd0 - shift_number;
  assign w_rsh_idx = shift_number - 5'd1;

  // An enable paired with a class it does not own counts as no enable; the
  // arith enable wins whenever it is effective.
  assign w_do_arith = enable_arith && (opselect == SEL_ARITH);
  assign w_do_memrd = enable_arith && (opselect == SEL_MEMRD);
  assign w_do_shift = enable_shift && (opselect == SEL_SHIFT);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred. Defaulting to the
  // registered values gives the hold behaviour for free.
  always_comb begin
    w_result = r_aluout;
    w_carry  = r_carry;
    w_valid  = 1'b0;

    if (w_do_arith) begin
      w_valid = 1'b1;
      w_carry = 1'b0;
      unique case (arith_op_e'(operation))
        OP_ADD:  begin
          w_result = w_add[DATA_WIDTH-1:0];
          w_carry  = w_add[DATA_WIDTH];
        end
        OP_HADD: begin
          w_result = {{(DATA_WIDTH-16){w_hadd[15]}}, w_hadd[15:0]};
          w_carry  = w_hadd[16];
        end
        OP_SUB:  begin
          w_result = aluin1 - aluin2;
          w_carry  = w_borrow;
        end
        OP_NOT:  w_result = ~aluin2;
        OP_AND:  w_result = aluin1 & aluin2;
        OP_OR:   w_result = aluin1 | aluin2;
        OP_XOR:  w_result = aluin1 ^ aluin2;
        OP_LHG:  w_result = {aluin2[15:0], 16'h0000};
      endcase
    end else if (w_do_memrd) begin
      w_valid = 1'b1;
      w_carry = 1'b0;
      case (load_op_e'(operation))
        LD_SB:   w_result = {{(DATA_WIDTH-8){aluin2[7]}}, aluin2[7:0]};
        LD_UB:   w_result = {{(DATA_WIDTH-8){1'b0}}, aluin2[7:0]};
        LD_SH:   w_result = {{(DATA_WIDTH-16){aluin2[15]}}, aluin2[15:0]};
        LD_UH:   w_result = {{(DATA_WIDTH-16){1'b0}}, aluin2[15:0]};
        default: w_result = aluin2;  // full word, including code 011
      endcase
    end else if (w_do_shift) begin
      w_valid = 1'b1;
      w_carry = 1'b0;
      if (operation[2]) begin
        w_result = aluin1;           // pass-through codes
      end else begin
        unique case (shift_op_e'(operation[1:0]))
          SH_SLL, SH_SLA: begin
            w_result = aluin1 << shift_number;
            if (shift_number != 5'd0) w_carry = aluin1[w_lsh_idx];
          end
          SH_SRL: begin
            w_result = aluin1 >> shift_number;
            if (shift_number != 5'd0) w_carry = aluin1[w_rsh_idx];
          end
          SH_SRA: begin
            w_result = $unsigned($signed(aluin1) >>> shift_number);
            if (shift_number != 5'd0) w_carry = aluin1[w_rsh_idx];
          end
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_aluout <= '0;
      r_carry  <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_aluout <= w_result;
      r_carry  <= w_carry;
      r_valid  <= w_valid;
    end
  end

  assign aluout       = r_aluout;
  assign carry        = r_carry;
  assign result_valid = r_valid;

endmodule

// File: tb/tb_alu_execute.sv
module tb_alu_execute;

  logic        clock;
  logic        reset;
  logic [31:0] aluin1;
  logic [31:0] aluin2;
  logic [2:0]  operation;
  logic [2:0]  opselect;
  logic [4:0]  shift_number;
  logic        enable_arith;
  logic        enable_shift;
  logic [31:0] aluout;
  logic        carry;
  logic        result_valid;

  int n_compared   = 0;
  int n_mismatched = 0;

  alu_execute #(.DATA_WIDTH(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .aluin1       (aluin1),
    .aluin2       (aluin2),
    .operation    (operation),
    .opselect     (opselect),
    .shift_number (shift_number),
    .enable_arith (enable_arith),
    .enable_shift (enable_shift),
    .aluout       (aluout),
    .carry        (carry),
    .result_valid (result_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        en_a;
    logic        en_s;
    logic [2:0]  opsel;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] exp_out;
    logic        exp_c;
    logic        exp_v;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] exp_out,
                       input logic exp_c, input logic exp_v);
    n_compared++;
    if (aluout !== exp_out || carry !== exp_c || result_valid !== exp_v) begin
      n_mismatched++;
      $display("FAIL %s: got aluout=%08h carry=%b valid=%b, want aluout=%08h carry=%b valid=%b",
               name, aluout, carry, result_valid, exp_out, exp_c, exp_v);
    end
  endtask

  task automatic drive(input logic en_a, input logic en_s, input logic [2:0] opsel,
                       input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    enable_arith = en_a;
    enable_shift = en_s;
    opselect     = opsel;
    operation    = op;
    aluin1       = a;
    aluin2       = b;
    shift_number = sh;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, 3'b000, 32'h0, 32'h0, 5'd0);
  endtask

  // Drive at the falling edge, let the rising edge capture, sample 1 ns later.
  task automatic step(input string name, input logic en_a, input logic en_s,
                      input logic [2:0] opsel, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                      input logic [31:0] exp_out, input logic exp_c, input logic exp_v);
    @(negedge clock);
    drive(en_a, en_s, opsel, op, a, b, sh);
    @(posedge clock);
    #1;
    check(name, exp_out, exp_c, exp_v);
  endtask

  initial begin
    //         name         ea    es    sel     op      a             b             sh     exp           c     v
    vecs.push_back('{"add_wrap",  1'b1, 1'b0, 3'b001, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 1'b1});
    vecs.push_back('{"add_small", 1'b1, 1'b0, 3'b001, 3'b000, 32'h0000_0001, 32'h0000_0002, 5'd0,  32'h0000_0003, 1'b0, 1'b1});
    vecs.push_back('{"sub_borrow",1'b1, 1'b0, 3'b001, 3'b010, 32'd5,         32'd7,         5'd0,  32'hFFFF_FFFE, 1'b1, 1'b1});
    vecs.push_back('{"sub_pos",   1'b1, 1'b0, 3'b001, 3'b010, 32'd7,         32'd5,         5'd0,  32'h0000_0002, 1'b0, 1'b1});
    vecs.push_back('{"hadd_ovf",  1'b1, 1'b0, 3'b001, 3'b001, 32'h1234_7FFF, 32'hABCD_0001, 5'd0,  32'hFFFF_8000, 1'b0, 1'b1});
    vecs.push_back('{"hadd_carry",1'b1, 1'b0, 3'b001, 3'b001, 32'h0000_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 1'b1});
    vecs.push_back('{"not",       1'b1, 1'b0, 3'b001, 3'b011, 32'h1111_1111, 32'h0F0F_00FF, 5'd0,  32'hF0F0_FF00, 1'b0, 1'b1});
    vecs.push_back('{"and",       1'b1, 1'b0, 3'b001, 3'b100, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0,  32'h0F00_0F00, 1'b0, 1'b1});
    vecs.push_back('{"or",        1'b1, 1'b0, 3'b001, 3'b101, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0,  32'hFF0F_FF0F, 1'b0, 1'b1});
    vecs.push_back('{"xor",       1'b1, 1'b0, 3'b001, 3'b110, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0,  32'hF00F_F00F, 1'b0, 1'b1});
    vecs.push_back('{"lhg",       1'b1, 1'b0, 3'b001, 3'b111, 32'h0,         32'h1234_ABCD, 5'd0,  32'hABCD_0000, 1'b0, 1'b1});
    vecs.push_back('{"ld_sb",     1'b1, 1'b0, 3'b101, 3'b000, 32'h0,         32'h0000_80F0, 5'd0,  32'hFFFF_FFF0, 1'b0, 1'b1});
    vecs.push_back('{"ld_ub",     1'b1, 1'b0, 3'b101, 3'b100, 32'h0,         32'h0000_80F0, 5'd0,  32'h0000_00F0, 1'b0, 1'b1});
    vecs.push_back('{"ld_sh",     1'b1, 1'b0, 3'b101, 3'b001, 32'h0,         32'h0000_80F0, 5'd0,  32'hFFFF_80F0, 1'b0, 1'b1});
    vecs.push_back('{"ld_uh",     1'b1, 1'b0, 3'b101, 3'b101, 32'h0,         32'h0000_80F0, 5'd0,  32'h0000_80F0, 1'b0, 1'b1});
    vecs.push_back('{"ld_word",   1'b1, 1'b0, 3'b101, 3'b011, 32'h0,         32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1'b1});
    vecs.push_back('{"ld_other",  1'b1, 1'b0, 3'b101, 3'b111, 32'h0,         32'h8765_4321, 5'd0,  32'h8765_4321, 1'b0, 1'b1});
    vecs.push_back('{"sra_4",     1'b0, 1'b1, 3'b000, 3'b011, 32'h8000_0001, 32'h0,         5'd4,  32'hF800_0000, 1'b0, 1'b1});
    vecs.push_back('{"sll_4",     1'b0, 1'b1, 3'b000, 3'b000, 32'h8000_0001, 32'h0,         5'd4,  32'h0000_0010, 1'b0, 1'b1});
    vecs.push_back('{"srl_1",     1'b0, 1'b1, 3'b000, 3'b010, 32'h8000_0001, 32'h0,         5'd1,  32'h4000_0000, 1'b1, 1'b1});
    vecs.push_back('{"sla_1",     1'b0, 1'b1, 3'b000, 3'b001, 32'h8000_0001, 32'h0,         5'd1,  32'h0000_0002, 1'b1, 1'b1});
    vecs.push_back('{"shift_pass",1'b0, 1'b1, 3'b000, 3'b100, 32'hDEAD_BEEF, 32'h0,         5'd3,  32'hDEAD_BEEF, 1'b0, 1'b1});
    vecs.push_back('{"srl_31",    1'b0, 1'b1, 3'b000, 3'b010, 32'hC000_0000, 32'h0,         5'd31, 32'h0000_0001, 1'b1, 1'b1});
    vecs.push_back('{"sra_0",     1'b0, 1'b1, 3'b000, 3'b011, 32'h8000_0001, 32'h0,         5'd0,  32'h8000_0001, 1'b0, 1'b1});
    vecs.push_back('{"sra_31",    1'b0, 1'b1, 3'b000, 3'b011, 32'h8000_0000, 32'h0,         5'd31, 32'hFFFF_FFFF, 1'b0, 1'b1});
    vecs.push_back('{"both_en",   1'b1, 1'b1, 3'b001, 3'b010, 32'd5,         32'd7,         5'd4,  32'hFFFF_FFFE, 1'b1, 1'b1});
    vecs.push_back('{"arith_sel0",1'b1, 1'b0, 3'b000, 3'b000, 32'd1,         32'd1,         5'd0,  32'hFFFF_FFFE, 1'b1, 1'b0});
    vecs.push_back('{"arith_sel4",1'b1, 1'b0, 3'b100, 3'b000, 32'd1,         32'd1,         5'd0,  32'hFFFF_FFFE, 1'b1, 1'b0});
    vecs.push_back('{"shift_sel1",1'b0, 1'b1, 3'b001, 3'b000, 32'd1,         32'd1,         5'd1,  32'hFFFF_FFFE, 1'b1, 1'b0});
    vecs.push_back('{"no_enable", 1'b0, 1'b0, 3'b001, 3'b000, 32'd9,         32'd9,         5'd0,  32'hFFFF_FFFE, 1'b1, 1'b0});

    reset = 1'b0;
    idle();
    #12;
    check("reset_state", 32'h0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Table vectors run one per cycle, so consecutive valid ops also exercise
    // back-to-back strobes.
    foreach (vecs[i]) begin
      step(vecs[i].name, vecs[i].en_a, vecs[i].en_s, vecs[i].opsel, vecs[i].op,
           vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].exp_out, vecs[i].exp_c, vecs[i].exp_v);
    end

    // Three back-to-back ops, then three idle cycles holding the third result.
    step("b2b_1", 1'b1, 1'b0, 3'b001, 3'b000, 32'd10, 32'd20, 5'd0, 32'd30, 1'b0, 1'b1);
    step("b2b_2", 1'b1, 1'b0, 3'b001, 3'b010, 32'd3,  32'd1,  5'd0, 32'd2,  1'b0, 1'b1);
    step("b2b_3", 1'b1, 1'b0, 3'b001, 3'b000, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'd1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step($sformatf("b2b_hold%0d", k), 1'b0, 1'b0, 3'b001, 3'b000, 32'd77, 32'd88, 5'd0,
           32'd1, 1'b1, 1'b0);
    end

    // Asynchronous reset between clock edges with an op in flight.
    step("pre_reset_op", 1'b1, 1'b0, 3'b001, 3'b000, 32'hFFFF_FFFF, 32'd5, 5'd0, 32'd4, 1'b1, 1'b1);
    @(negedge clock);
    drive(1'b1, 1'b0, 3'b001, 3'b000, 32'd4, 32'd4, 5'd0);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", 32'h0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    check("reset_held_active_inputs", 32'h0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("post_reset_op", 32'd8, 1'b0, 1'b1);
    step("post_reset_idle", 1'b0, 1'b0, 3'b001, 3'b000, 32'd0, 32'd0, 5'd0, 32'd8, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
